// File: rtl/serial_receiver.sv
// serial_receiver
// Receive end of the two-wire clock+data byte link. The far-end transmitter
// drives clk_in and data_in asynchronously. Both lines are synchronised into
// clk_sys. The block detects the start condition, shifts in 8 data bits LSB
// first, checks the pad/ACK/STOP trailer slots, and offers each good byte on a
// valid/ready interface.
//
// Ports:
//   clk_sys      in   system clock, rising edge
//   reset        in   synchronous, active-high
//   clk_in       in   serial clock from the link (idles high, asynchronous)
//   data_in      in   serial data from the link (idles high, asynchronous)
//   ready        in   consumer accepts data when valid & ready
//   data[7:0]    out  received byte
//   valid        out  data holds an unconsumed byte
//   busy         out  frame in progress
//   frame_error  out  one-cycle pulse: bad trailer, timeout or restart/stop mid-frame
//   overrun      out  one-cycle pulse: good byte dropped, previous byte still pending
module serial_receiver #(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TO_W           = 16
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       clk_in,
    input  logic       data_in,
    input  logic       ready,
    output logic [7:0] data,
    output logic       valid,
    output logic       busy,
    output logic       frame_error,
    output logic       overrun
);

    typedef enum logic [1:0] {
        WAIT_LINE = 2'd0,
        IDLE      = 2'd1,
        RECV      = 2'd2,
        CHECK     = 2'd3
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_MAX  = {TO_W{1'b1}};

    // Synchronisers: [0] first flop, [1] synced value, [2] previous synced value.
    // Both lines use identical depth, so the start and stop detectors compare
    // clock and data samples that were taken in the same clk_sys cycle.
    logic [2:0]      csync_q, csync_d;
    logic [2:0]      dsync_q, dsync_d;

    state_t          state_q, state_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            ack_ok_q, ack_ok_d;
    logic            stop_ok_q, stop_ok_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            frame_error_q, frame_error_d;
    logic            overrun_q, overrun_d;

    logic            c2_s, c3_s, d2_s, d3_s;
    logic            rise_clk_s, start_cond_s, stop_cond_s;
    logic [TO_W-1:0] to_inc_s;

    assign c2_s = csync_q[1];
    assign c3_s = csync_q[2];
    assign d2_s = dsync_q[1];
    assign d3_s = dsync_q[2];

    assign rise_clk_s   = c2_s & ~c3_s;
    assign start_cond_s = c2_s & d3_s & ~d2_s;   // data falls while clock high
    assign stop_cond_s  = c2_s & d2_s & ~d3_s;   // data rises while clock high

    // Saturating increment, so a stuck line never wraps the counter.
    assign to_inc_s = (to_q == TO_MAX) ? to_q : (to_q + {{(TO_W-1){1'b0}}, 1'b1});

    // Next-state logic for the synchronisers, frame FSM, datapath and outputs.
    always_comb begin
        csync_d       = {csync_q[1:0], clk_in};
        dsync_d       = {dsync_q[1:0], data_in};
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        to_d          = to_q;
        ack_ok_d      = ack_ok_q;
        stop_ok_d     = stop_ok_q;
        data_d        = data_q;
        frame_error_d = 1'b0;
        overrun_d     = 1'b0;

        // Consumer handshake; CHECK below may override with a fresh byte.
        if (valid_q && ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        case (state_q)
            WAIT_LINE: begin
                // Only arm once the line has been seen idle; a start
                // condition here is ignored.
                if (c2_s && d2_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_LINE;
                end
            end
            IDLE: begin
                if (start_cond_s) begin
                    state_d   = RECV;
                    bit_cnt_d = 4'd0;
                    to_d      = {TO_W{1'b0}};
                    shift_d   = 8'd0;
                    ack_ok_d  = 1'b0;
                    stop_ok_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            RECV: begin
                if (start_cond_s) begin
                    // Restart: abandon the partial frame and receive afresh.
                    frame_error_d = 1'b1;
                    state_d       = RECV;
                    bit_cnt_d     = 4'd0;
                    to_d          = {TO_W{1'b0}};
                    shift_d       = 8'd0;
                    ack_ok_d      = 1'b0;
                    stop_ok_d     = 1'b0;
                end else if (stop_cond_s) begin
                    frame_error_d = 1'b1;
                    state_d       = IDLE;
                end else if (rise_clk_s) begin
                    to_d      = {TO_W{1'b0}};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q < 4'd8) begin
                        shift_d[bit_cnt_q[2:0]] = d2_s;
                    end else if (bit_cnt_q == 4'd9) begin
                        ack_ok_d = ~d2_s;
                    end else if (bit_cnt_q == 4'd10) begin
                        stop_ok_d = ~d2_s;
                        bit_cnt_d = 4'd0;
                        state_d   = CHECK;
                    end else begin
                        // Pad slot: sampled and discarded.
                        shift_d = shift_q;
                    end
                end else begin
                    to_d = to_inc_s;
                    if (to_inc_s == TO_LAST) begin
                        frame_error_d = 1'b1;
                        state_d       = WAIT_LINE;
                    end else begin
                        state_d = RECV;
                    end
                end
            end
            CHECK: begin
                state_d = WAIT_LINE;
                if (!(ack_ok_q && stop_ok_q)) begin
                    frame_error_d = 1'b1;
                end else if (!valid_q || ready) begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = WAIT_LINE;
            end
        endcase

        busy_d = (state_d == RECV);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            csync_q       <= 3'b111;
            dsync_q       <= 3'b111;
            state_q       <= WAIT_LINE;
            bit_cnt_q     <= 4'd0;
            shift_q       <= 8'd0;
            to_q          <= {TO_W{1'b0}};
            ack_ok_q      <= 1'b0;
            stop_ok_q     <= 1'b0;
            data_q        <= 8'd0;
            valid_q       <= 1'b0;
            busy_q        <= 1'b0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            csync_q       <= csync_d;
            dsync_q       <= dsync_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            to_q          <= to_d;
            ack_ok_q      <= ack_ok_d;
            stop_ok_q     <= stop_ok_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            busy_q        <= busy_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
        end
    end

    assign data        = data_q;
    assign valid       = valid_q;
    assign busy        = busy_q;
    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_serial_receiver.sv
// Directed bench for serial_receiver. Link inputs change on the falling edge
// of clk_sys; outputs are sampled on the falling edge as well.
module tb_serial_receiver;

    logic       clk_sys = 1'b0;
    logic       reset   = 1'b1;
    logic       clk_in  = 1'b1;
    logic       data_in = 1'b1;
    logic       ready   = 1'b1;
    logic [7:0] data;
    logic       valid, busy, frame_error, overrun;

    int n_chk  = 0;
    int n_fail = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int v_cnt  = 0;
    int lat    = 0;
    int fe_at  = 0;
    logic busy_after = 1'b1;

    serial_receiver #(.TIMEOUT_CYCLES(100), .TO_W(16)) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .clk_in      (clk_in),
        .data_in     (data_in),
        .ready       (ready),
        .data        (data),
        .valid       (valid),
        .busy        (busy),
        .frame_error (frame_error),
        .overrun     (overrun)
    );

    always #5 clk_sys = ~clk_sys;

    // Pulse and valid-cycle counters, sampled away from the active edge.
    always @(negedge clk_sys) begin
        if (frame_error) fe_cnt++;
        if (overrun)     ov_cnt++;
        if (valid)       v_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic clr();
        #1;
        fe_cnt = 0;
        ov_cnt = 0;
        v_cnt  = 0;
    endtask

    // Start condition: data falls while clock high, then clock goes low.
    task automatic drv_start();
        data_in = 1'b0;
        wait_cyc(4);
        clk_in = 1'b0;
        wait_cyc(2);
    endtask

    task automatic drv_slot(input logic b);
        data_in = b;
        wait_cyc(4);
        clk_in = 1'b1;
        wait_cyc(4);
        clk_in = 1'b0;
        wait_cyc(2);
    endtask

    // Eleventh slot: records cycles from the raw clock edge to valid, then
    // releases data high (stop condition) to idle the line.
    task automatic drv_last(input logic b);
        data_in = b;
        wait_cyc(4);
        clk_in = 1'b1;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk_sys);
            if (valid && lat == 0) lat = i;
            if (i == 4) data_in = 1'b1;
        end
    endtask

    task automatic send_body(input logic [7:0] b, input logic ack);
        for (int i = 0; i < 8; i++) drv_slot(b[i]);
        drv_slot(1'b0);
        drv_slot(ack);
        drv_last(1'b0);
        wait_cyc(4);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ack);
        drv_start();
        send_body(b, ack);
    endtask

    logic [7:0] bytes [5] = '{8'hA5, 8'h00, 8'hFF, 8'h01, 8'h80};
    logic [7:0] part;

    initial begin
        // Reset state
        wait_cyc(3);
        check("rst_data",  32'(data),        32'h00);
        check("rst_valid", 32'(valid),       32'h0);
        check("rst_busy",  32'(busy),        32'h0);
        check("rst_fe",    32'(frame_error), 32'h0);
        check("rst_ov",    32'(overrun),     32'h0);
        reset = 1'b0;
        wait_cyc(6);

        // Good frames with ready high: one-cycle valid, 4-cycle latency
        for (int k = 0; k < 5; k++) begin
            clr();
            send_byte(bytes[k], 1'b0);
            check("good_data",  32'(data),            32'(bytes[k]));
            check("good_vcnt",  32'(v_cnt),           32'd1);
            check("good_lat",   32'(lat),             32'd4);
            check("good_err",   32'(fe_cnt + ov_cnt), 32'd0);
            check("good_busy",  32'(busy),            32'h0);
        end

        // ACK slot high: frame error, nothing delivered
        clr();
        send_byte(8'h5A, 1'b1);
        check("ack_fe",    32'(fe_cnt), 32'd1);
        check("ack_vcnt",  32'(v_cnt),  32'd0);
        check("ack_valid", 32'(valid),  32'h0);
        check("ack_data",  32'(data),   32'h80);

        // Two frames with ready low: second is dropped as overrun
        ready = 1'b0;
        clr();
        send_byte(8'h3C, 1'b0);
        check("ovr_first_data",  32'(data),  32'h3C);
        check("ovr_first_valid", 32'(valid), 32'h1);
        send_byte(8'hC3, 1'b0);
        check("ovr_data",  32'(data),   32'h3C);
        check("ovr_valid", 32'(valid),  32'h1);
        check("ovr_pulse", 32'(ov_cnt), 32'd1);
        check("ovr_fe",    32'(fe_cnt), 32'd0);
        ready = 1'b1;
        wait_cyc(1);
        check("ovr_accept_valid", 32'(valid), 32'h0);
        check("ovr_accept_data",  32'(data),  32'h3C);

        // Stall after edge 4 with clock held low: timeout after 100 cycles
        clr();
        drv_start();
        drv_slot(1'b1);
        drv_slot(1'b1);
        drv_slot(1'b1);
        data_in = 1'b1;
        wait_cyc(4);
        clk_in = 1'b1;
        fe_at = 0;
        for (int i = 1; i <= 110; i++) begin
            @(negedge clk_sys);
            if (i == 4) clk_in = 1'b0;
            if (i == 50) check("to_busy_mid", 32'(busy), 32'h1);
            if (fe_at != 0 && i == fe_at + 1) busy_after = busy;
            if (frame_error && fe_at == 0) fe_at = i;
        end
        check("to_fe_cycle", 32'(fe_at),      32'd102);
        check("to_fe_cnt",   32'(fe_cnt),     32'd1);
        check("to_busy",     32'(busy_after), 32'h0);
        clk_in = 1'b1;
        wait_cyc(2);
        data_in = 1'b1;
        wait_cyc(6);
        clr();
        send_byte(8'h11, 1'b0);
        check("to_next_data", 32'(data),   32'h11);
        check("to_next_vcnt", 32'(v_cnt),  32'd1);
        check("to_next_fe",   32'(fe_cnt), 32'd0);

        // Start condition after edge 5 (plus one more edge), then full frame
        clr();
        drv_start();
        part = 8'h33;
        for (int i = 0; i < 5; i++) drv_slot(part[i]);
        data_in = 1'b1;
        wait_cyc(4);
        clk_in = 1'b1;
        wait_cyc(4);
        drv_start();
        send_body(8'h96, 1'b0);
        check("rs_fe",   32'(fe_cnt), 32'd1);
        check("rs_data", 32'(data),   32'h96);
        check("rs_vcnt", 32'(v_cnt),  32'd1);
        check("rs_ov",   32'(ov_cnt), 32'd0);

        // Reset after edge 6 while a byte is pending
        ready = 1'b0;
        send_byte(8'h24, 1'b0);
        check("mr_pre_valid", 32'(valid), 32'h1);
        drv_start();
        part = 8'h5C;
        for (int i = 0; i < 6; i++) drv_slot(part[i]);
        check("mr_pre_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        wait_cyc(1);
        reset = 1'b0;
        check("mr_valid", 32'(valid),       32'h0);
        check("mr_data",  32'(data),        32'h00);
        check("mr_busy",  32'(busy),        32'h0);
        check("mr_fe",    32'(frame_error), 32'h0);
        check("mr_ov",    32'(overrun),     32'h0);
        clr();
        drv_slot(part[6]);
        drv_slot(part[7]);
        drv_slot(1'b0);
        drv_slot(1'b0);
        drv_last(1'b0);
        wait_cyc(4);
        check("mr_rest_vcnt", 32'(v_cnt),  32'd0);
        check("mr_rest_fe",   32'(fe_cnt), 32'd0);
        check("mr_rest_ov",   32'(ov_cnt), 32'd0);
        ready = 1'b1;
        clr();
        send_byte(8'h42, 1'b0);
        check("mr_next_data", 32'(data),   32'h42);
        check("mr_next_vcnt", 32'(v_cnt),  32'd1);
        check("mr_next_err",  32'(fe_cnt + ov_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_receiver.md
Name: serial_receiver

Overview:
- Receive end of the two-wire clock+data byte link.
- Samples `clk_in` and `data_in`, which are driven by the far-end transmitter, in the `clk_sys` domain.
- Detects the start condition, shifts in 8 bits LSB first, checks the trailer slots, and presents each good byte on a valid/ready interface to the local consumer.
- Sits between the board pins and the clock/command decode logic.

Parameters:
- TIMEOUT_CYCLES, 65535: `clk_sys` cycles with no `clk_in` rising edge mid-frame before the frame is aborted; must be < 2^TO_W.
- TO_W, 16: width of the timeout counter.

Ports:
- clk_sys  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high.
- clk_in  input  1  serial clock from the link; idles high; asynchronous to `clk_sys`.
- data_in  input  1  serial data from the link; idles high; asynchronous.
- ready  input  1  consumer accepts `data` when `valid` and `ready` are both high.
- data  output  8  received byte.
- valid  output  1  `data` holds an unconsumed byte.
- busy  output  1  high while a frame is in progress (state RECV).
- frame_error  output  1  one-cycle pulse: bad trailer, timeout, or restart mid-frame.
- overrun  output  1  one-cycle pulse: a good frame was dropped because the previous byte was still pending.

Behaviour:
- Reset values: `data`=0, `valid`=0, `busy`=0, `frame_error`=0, `overrun`=0; state=WAIT_LINE; bit counter=0; shift register=0; timeout counter=0. Sync flops reset to 1.
- Input sync:
  - `clk_in` and `data_in` each pass through 2 flops, plus a third flop for edge detect. Both paths have equal delay.
  - rise_clk = `c2` & !`c3`.
  - start_cond = `c2` & `d3` & !`d2` (data falls while clock is high).
  - stop_cond = `c2` & `d2` & !`d3`.
- Link timing: each `clk_in` half period is ≥4 `clk_sys` cycles. Data changes only while `clk_in` is low, except at the start and stop conditions.
- Frame, counting `clk_in` rising edges after the start condition:
  - edges 1–8: data bits 0–7, LSB first. Sample `d2` on rise_clk.
  - edge 9: pad slot; sampled and discarded.
  - edge 10: ACK slot; must be 0.
  - edge 11: STOP slot; must be 0.
  - After edge 11 the line returns to `clk`=1, `data`=1.
- States:
  - WAIT_LINE: wait for `c2`=1 and `d2`=1, then go to IDLE. Start conditions are ignored here.
  - IDLE: on start_cond → RECV; clear bit counter, timeout counter and shift register.
  - RECV:
    - `busy`=1.
    - On each rise_clk: increment the bit counter (0..10) and clear the timeout counter. For counts 0–7, shift `d2` into bit [count].
    - On the rise_clk with count==9: latch ack_ok = !`d2`.
    - On the rise_clk with count==10: latch stop_ok = !`d2` and go to CHECK.
    - Otherwise increment the timeout counter each cycle. When it reaches TIMEOUT_CYCLES-1: pulse `frame_error`, go to WAIT_LINE.
    - start_cond in RECV: pulse `frame_error`, restart RECV with counters cleared (no WAIT_LINE).
    - stop_cond in RECV: pulse `frame_error`, go to IDLE.
  - CHECK (1 cycle), then WAIT_LINE:
    - Trailer bad (ack_ok & stop_ok not both 1): pulse `frame_error`; `data`/`valid` unchanged.
    - Good and `valid`=0, or `valid`=1 with `ready`=1 this cycle: load `data`, `valid`=1 next cycle.
    - Good and `valid`=1 with `ready`=0: pulse `overrun`; new byte dropped; old `data` kept.
- Latency: `valid` rises 4 `clk_sys` cycles after the raw 11th `clk_in` rising edge (2 sync + edge detect + CHECK).
- Handshake:
  - `valid` falls the cycle after `valid` & `ready`, unless CHECK reloads `data` in that same cycle.
  - `data` is stable while `valid`=1 and not accepted.
  - `ready` has no effect when `valid`=0.
- Timeout counter saturates; it never wraps.
- `reset` mid-frame: all state is cleared next cycle and goes to WAIT_LINE; no pulses are emitted; the partial byte is lost.

Test Plan:
- Loopback with the transmitter block, byte 0xA5, `ready`=1 → `valid` for 1 cycle, `data`=0xA5, no errors. Repeat for 0x00, 0xFF, 0x01, 0x80.
- Two frames 0x3C then 0xC3, `ready`=0 throughout → `data`=0x3C with `valid` held; one `overrun` pulse at the second CHECK; `data` stays 0x3C. Then `ready`=1 → `valid` drops next cycle.
- Bit-banged frame 0x5A with ACK slot=1 → one `frame_error` pulse, `valid` stays 0, state returns to IDLE after the line idles.
- Frame stalled after edge 4 with `clk_in` held low, TIMEOUT_CYCLES=100 → `frame_error` exactly 100 cycles after the last synced rise; `busy`=0 next; a following good frame 0x11 is received.
- Start condition injected after edge 5, then a full frame 0x96 → one `frame_error`, then `data`=0x96 `valid`; the partial byte is discarded.
- `reset` asserted for 1 cycle after edge 6 → all outputs 0 next cycle. The remainder of the frame produces no `valid` and no errors; the next full frame 0x42 is received.
